apb_regfile_slave: RTL and testbench



---
 rtl/apb_regfile_slave.sv | 163 ++++++++++++++++
 tb/tb_apb_regfile_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// APB completer serving a bank of 32-bit byte-strobed registers with programmable wait states.
// Optional protection checking on the upper half of the bank is enabled by defining APB_SLV_PROT_EN.
module apb_regfile_slave #(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic [31:0]              paddr,
  input  logic                     pwrite,
  input  logic [2:0]               pprot,
  input  logic [31:0]              pwdata,
  input  logic [3:0]               pstrb,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_REGS*32-1:0]   reg_q
);

  localparam int          IDXW = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    COMPLETE
  } state_t;

  state_t                        state_q, state_d;
  logic [31:0]                   addr_q, addr_d;
  logic [31:0]                   wdata_q, wdata_d;
  logic                          write_q, write_d;
  logic [3:0]                    strb_q, strb_d;
  logic [2:0]                    prot_q, prot_d;
  logic [3:0]                    wait_cnt_q, wait_cnt_d;
  logic                          pready_q, pready_d;
  logic                          pslverr_q, pslverr_d;
  logic [31:0]                   prdata_q, prdata_d;
  logic [NUM_REGS-1:0][31:0]     regs_q, regs_d;

  logic [32:0]                   diff;
  logic [31:0]                   offset;
  logic [IDXW-1:0]               idx;
  logic                          range_err;
  logic                          align_err;
  logic                          prot_err;
  logic                          acc_err;
  logic                          unused_prot;

  // 33-bit subtraction: the borrow bit flags addresses below the window
  assign diff      = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign offset    = diff[31:0];
  assign idx       = offset[IDXW+1:2];
  assign range_err = diff[32] || (offset >= SPAN);
  assign align_err = |addr_q[1:0];

`ifdef APB_SLV_PROT_EN
  assign prot_err  = ~prot_q[0] & idx[IDXW-1];
`else
  assign prot_err  = 1'b0;
`endif

  assign acc_err     = range_err | align_err | prot_err;
  assign unused_prot = ^prot_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    strb_d     = strb_q;
    prot_d     = prot_q;
    wait_cnt_d = wait_cnt_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    regs_d     = regs_q;

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d     = paddr;
          write_d    = pwrite;
          wdata_d    = pwdata;
          strb_d     = pstrb;
          prot_d     = pprot;
          wait_cnt_d = 4'(WAIT_STATES);
          state_d    = ACCESS;
        end
      end

      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (wait_cnt_q != 4'd0) begin
          if (penable) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end
        end else begin
          pready_d  = 1'b1;
          pslverr_d = acc_err;
          if (!acc_err) begin
            if (write_q) begin
              for (int unsigned n = 0; n < 4; n++) begin
                if (strb_q[n]) begin
                  regs_d[idx][8*n +: 8] = wdata_q[8*n +: 8];
                end
              end
            end else begin
              prdata_d = regs_q[idx];
            end
          end
          state_d = COMPLETE;
        end
      end

      COMPLETE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      strb_q     <= '0;
      prot_q     <= '0;
      wait_cnt_q <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      regs_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      strb_q     <= strb_d;
      prot_q     <= prot_d;
      wait_cnt_q <= wait_cnt_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      regs_q     <= regs_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign reg_q   = regs_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: one instance with 0 wait states, one with 3.
module tb_apb_regfile_slave;
  localparam int NR = 16;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic              preset = 1'b1;
  logic              psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]       paddr = '0, pwdata = '0;
  logic [2:0]        pprot = '0;
  logic [3:0]        pstrb = '0;
  logic [31:0]       prdata0, prdata3;
  logic              pready0, pready3, pslverr0, pslverr3;
  logic [NR*32-1:0]  regq0, regq3;

  int vecs = 0;
  int errs = 0;
  logic [31:0] exp0 [NR];
  logic [31:0] exp3 [NR];

  apb_regfile_slave #(.NUM_REGS(NR), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0), .reg_q(regq0));

  apb_regfile_slave #(.NUM_REGS(NR), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3), .reg_q(regq3));

  function automatic logic [NR*32-1:0] pack(input bit which);
    logic [NR*32-1:0] r;
    for (int i = 0; i < NR; i++) r[32*i +: 32] = which ? exp3[i] : exp0[i];
    return r;
  endfunction

  // Starts at a point just after a rising edge; returns just after the edge closing the transfer.
  task automatic xfer(input bit which, input logic [31:0] a, input bit w, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p,
                      output logic [31:0] rd, output logic err, output int lat);
    paddr = a; pwrite = w; pwdata = d; pstrb = s; pprot = p; penable = 1'b0;
    if (which) psel3 = 1'b1; else psel0 = 1'b1;
    @(posedge pclk); #1;
    penable = 1'b1;
    // bus scrambled during access: completer must use setup-phase values
    paddr = ~a; pwdata = ~d; pstrb = ~s; pwrite = ~w; pprot = ~p;
    lat = 1; rd = '0; err = 1'b0;
    forever begin
      @(negedge pclk);
      if (which ? pready3 : pready0) break;
      if (lat >= 20) begin
        vecs++; errs++;
        $display("FAIL timeout: pready not seen after %0d cycles, required within 20", lat);
        break;
      end
      @(posedge pclk); #1;
      lat++;
    end
    rd  = which ? prdata3 : prdata0;
    err = which ? pslverr3 : pslverr0;
    @(posedge pclk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < NR; i++) begin exp0[i] = '0; exp3[i] = '0; end
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    vecs++; if (pready0 !== 1'b0) begin errs++; $display("FAIL rst_pready: got %b want 0", pready0); end
    vecs++; if (pslverr0 !== 1'b0) begin errs++; $display("FAIL rst_pslverr: got %b want 0", pslverr0); end
    vecs++; if (prdata0 !== 32'h0) begin errs++; $display("FAIL rst_prdata: got %h want 0", prdata0); end
    vecs++; if (regq0 !== pack(0)) begin errs++; $display("FAIL rst_regs0: got %h want 0", regq0); end
    vecs++; if (regq3 !== pack(1)) begin errs++; $display("FAIL rst_regs3: got %h want 0", regq3); end
    @(posedge pclk); #1;
  endtask

  task automatic test_read_basic;
    logic [31:0] rd; logic err; int lat;
    xfer(0, 32'h0C, 0, 32'h0, 4'hF, 3'b001, rd, err, lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL rd_lat: got %0d want 2", lat); end
    vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL rd_data: got %h want 0", rd); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL rd_err: got %b want 0", err); end
  endtask

  task automatic test_strobe;
    logic [31:0] rd; logic err; int lat;
    xfer(0, 32'h08, 1, 32'hDEADBEEF, 4'b0101, 3'b001, rd, err, lat);
    exp0[2] = 32'h00AD00EF;
    vecs++; if (lat !== 2 || err !== 1'b0) begin errs++; $display("FAIL wr1_resp: got lat %0d err %b want 2 0", lat, err); end
    vecs++; if (regq0[95:64] !== 32'h00AD00EF) begin errs++; $display("FAIL wr1_reg: got %h want 00ad00ef", regq0[95:64]); end
    xfer(0, 32'h08, 0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    vecs++; if (rd !== 32'h00AD00EF) begin errs++; $display("FAIL wr1_rb: got %h want 00ad00ef", rd); end
    xfer(0, 32'h08, 1, 32'h11223344, 4'b1010, 3'b001, rd, err, lat);
    exp0[2] = 32'h11AD33EF;
    vecs++; if (regq0 !== pack(0)) begin errs++; $display("FAIL wr2_bank: got %h want %h", regq0[95:64], exp0[2]); end
    xfer(0, 32'h08, 1, 32'hFFFFFFFF, 4'b0000, 3'b001, rd, err, lat);
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL strb0_err: got %b want 0", err); end
    vecs++; if (regq0 !== pack(0)) begin errs++; $display("FAIL strb0_bank: got %h want %h", regq0[95:64], exp0[2]); end
    xfer(0, 32'h08, 0, 32'h0, 4'hF, 3'b001, rd, err, lat);
    vecs++; if (rd !== 32'h11AD33EF) begin errs++; $display("FAIL wr2_rb: got %h want 11ad33ef", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic err; int lat;
    xfer(1, 32'h04, 1, 32'hCAFEF00D, 4'hF, 3'b001, rd, err, lat);
    exp3[1] = 32'hCAFEF00D;
    vecs++; if (lat !== 5) begin errs++; $display("FAIL b2b_wlat: got %0d want 5", lat); end
    vecs++; if (regq3 !== pack(1)) begin errs++; $display("FAIL b2b_wreg: got %h want cafef00d", regq3[63:32]); end
    xfer(1, 32'h04, 0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    vecs++; if (lat !== 5) begin errs++; $display("FAIL b2b_rlat: got %0d want 5", lat); end
    vecs++; if (rd !== 32'hCAFEF00D || err !== 1'b0) begin errs++; $display("FAIL b2b_rdata: got %h/%b want cafef00d/0", rd, err); end
    @(negedge pclk);
    vecs++; if (pready3 !== 1'b0 || pslverr3 !== 1'b0 || prdata3 !== 32'h0) begin
      errs++; $display("FAIL b2b_clear: got rdy %b err %b data %h want 0 0 0", pready3, pslverr3, prdata3);
    end
    @(posedge pclk); #1;
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic err; int lat;
    xfer(0, 32'h3C, 1, 32'hA5A55A5A, 4'hF, 3'b001, rd, err, lat);
    exp0[15] = 32'hA5A55A5A;
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL last_wr_err: got %b want 0", err); end
    xfer(0, 32'h3C, 0, 32'h0, 4'hF, 3'b001, rd, err, lat);
    vecs++; if (rd !== 32'hA5A55A5A) begin errs++; $display("FAIL last_rd: got %h want a5a55a5a", rd); end
    xfer(0, 32'h40, 0, 32'h0, 4'hF, 3'b001, rd, err, lat);
    vecs++; if (err !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      errs++; $display("FAIL oor_rd: got err %b data %h lat %0d want 1 0 2", err, rd, lat);
    end
    xfer(0, 32'h06, 1, 32'hDEADBEEF, 4'hF, 3'b001, rd, err, lat);
    vecs++; if (err !== 1'b1 || rd !== 32'h0) begin errs++; $display("FAIL mis_wr: got err %b data %h want 1 0", err, rd); end
    xfer(0, 32'h44, 1, 32'hDEADBEEF, 4'hF, 3'b001, rd, err, lat);
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL oor_wr: got err %b want 1", err); end
    vecs++; if (regq0 !== pack(0)) begin errs++; $display("FAIL err_bank: got %h want %h", regq0, pack(0)); end
  endtask

  task automatic test_prot;
    logic [31:0] rd; logic err; int lat;
    logic exp_err;
`ifdef APB_SLV_PROT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    xfer(0, 32'h20, 1, 32'h5678, 4'hF, 3'b000, rd, err, lat);
    if (!exp_err) exp0[8] = 32'h5678;
    vecs++; if (err !== exp_err) begin errs++; $display("FAIL prot_uwr_err: got %b want %b", err, exp_err); end
    vecs++; if (regq0[287:256] !== exp0[8]) begin errs++; $display("FAIL prot_uwr_reg: got %h want %h", regq0[287:256], exp0[8]); end
    xfer(0, 32'h20, 1, 32'h1234, 4'hF, 3'b001, rd, err, lat);
    exp0[8] = 32'h1234;
    vecs++; if (err !== 1'b0 || regq0[287:256] !== 32'h1234) begin
      errs++; $display("FAIL prot_pwr: got err %b reg %h want 0 00001234", err, regq0[287:256]);
    end
    xfer(0, 32'h20, 0, 32'h0, 4'hF, 3'b000, rd, err, lat);
    vecs++; if (err !== exp_err || rd !== (exp_err ? 32'h0 : 32'h1234)) begin
      errs++; $display("FAIL prot_urd: got err %b data %h want %b %h", err, rd, exp_err, exp_err ? 32'h0 : 32'h1234);
    end
    xfer(0, 32'h1C, 1, 32'h77, 4'hF, 3'b000, rd, err, lat);
    exp0[7] = 32'h77;
    vecs++; if (err !== 1'b0 || regq0 !== pack(0)) begin errs++; $display("FAIL prot_low: got err %b reg7 %h want 0 00000077", err, regq0[255:224]); end
  endtask

  task automatic test_abort;
    logic [31:0] rd; logic err; int lat;
    int seen;
    paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h99; pstrb = 4'hF; pprot = 3'b001;
    psel3 = 1'b1; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      if (pready3 !== 1'b0) seen++;
    end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL abort_rdy: got %0d pready cycles want 0", seen); end
    vecs++; if (regq3 !== pack(1)) begin errs++; $display("FAIL abort_bank: got %h want %h", regq3[95:64], exp3[2]); end
    @(posedge pclk); #1;
    xfer(1, 32'h04, 0, 32'h0, 4'hF, 3'b001, rd, err, lat);
    vecs++; if (rd !== 32'hCAFEF00D || lat !== 5) begin errs++; $display("FAIL abort_next: got %h lat %0d want cafef00d 5", rd, lat); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic err; int lat;
    int seen;
    paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h0BADCAFE; pstrb = 4'hF; pprot = 3'b001;
    psel0 = 1'b1; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1 preset = 1'b0; psel0 = 1'b0; penable = 1'b0;
    for (int i = 0; i < NR; i++) begin exp0[i] = '0; exp3[i] = '0; end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      if (pready0 !== 1'b0) seen++;
    end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL rstmid_rdy: got %0d pready cycles want 0", seen); end
    vecs++; if (regq0 !== pack(0)) begin errs++; $display("FAIL rstmid_bank: got %h want 0", regq0); end
    @(posedge pclk); #1;
    xfer(0, 32'h00, 1, 32'h13579BDF, 4'hF, 3'b001, rd, err, lat);
    vecs++; if (err !== 1'b0 || lat !== 2 || regq0[31:0] !== 32'h13579BDF) begin
      errs++; $display("FAIL rstmid_wr: got err %b lat %0d reg %h want 0 2 13579bdf", err, lat, regq0[31:0]);
    end
    xfer(0, 32'h00, 0, 32'h0, 4'hF, 3'b001, rd, err, lat);
    vecs++; if (rd !== 32'h13579BDF) begin errs++; $display("FAIL rstmid_rd: got %h want 13579bdf", rd); end
  endtask

  initial begin
    test_reset;
    test_read_basic;
    test_strobe;
    test_back_to_back;
    test_errors;
    test_prot;
    test_abort;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
